// File: rtl/int_ctrl_if.sv
// Bundle between the interrupt controller and the control unit / status register.
// The master side drives requests and handshakes; the slave side is the controller.
interface int_ctrl_if #(
  parameter int unsigned NIRQ  = 4,
  parameter int unsigned VEC_W = 8
);
  localparam int unsigned ID_W = $clog2(NIRQ);

  logic [NIRQ-1:0]  irq;
  logic             mask_wr;
  logic [NIRQ-1:0]  mask_din;
  logic             gie_set;
  logic             gie_clr;
  logic             int_ack;
  logic             reti;

  logic             irq_req;
  logic [ID_W-1:0]  irq_id;
  logic [VEC_W-1:0] irq_vec;
  logic             int_save;
  logic             int_load;
  logic             int_wreg;
  logic             in_service;
  logic [NIRQ-1:0]  pending;
  logic [NIRQ-1:0]  mask;
  logic             gie;

  modport master (
    output irq, mask_wr, mask_din, gie_set, gie_clr, int_ack, reti,
    input  irq_req, irq_id, irq_vec, int_save, int_load, int_wreg,
           in_service, pending, mask, gie
  );

  modport slave (
    input  irq, mask_wr, mask_din, gie_set, gie_clr, int_ack, reti,
    output irq_req, irq_id, irq_vec, int_save, int_load, int_wreg,
           in_service, pending, mask, gie
  );
endinterface

// File: rtl/int_ctrl.sv
// Non-nesting interrupt controller: edge-latched requests, fixed priority (index 0 highest),
// entry/return handshake with the control unit and save/load strobes for the status register.
module int_ctrl #(
  parameter int unsigned NIRQ       = 4,
  parameter int unsigned VEC_W      = 8,
  parameter int unsigned VEC_BASE   = 32'h10,
  parameter int unsigned VEC_STRIDE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  int_ctrl_if.slave  bus
);
  localparam int unsigned ID_W = $clog2(NIRQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SAVE,
    S_SERVICE,
    S_RESTORE
  } state_t;

  state_t           state, state_nxt;
  logic [NIRQ-1:0]  irq_d, pending, mask, eligible, edges, clr;
  logic             gie;
  logic [ID_W-1:0]  irq_id, win_id;
  logic [VEC_W-1:0] irq_vec, win_vec;
  logic             win_any;
  logic             irq_req, int_save, int_load, in_service;

  assign edges    = bus.irq & ~irq_d;
  assign eligible = pending & mask;

  // Lowest set index of eligible wins
  always_comb begin
    win_id  = '0;
    win_any = 1'b0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (eligible[i] && !win_any) begin
        win_id  = ID_W'(i);
        win_any = 1'b1;
      end
    end
    win_vec = VEC_W'(VEC_BASE + VEC_STRIDE * 32'(win_id));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (gie && win_any) state_nxt = S_REQ;
      // Ack outranks withdrawal when both occur in the same cycle
      S_REQ:     if (bus.int_ack) state_nxt = S_SAVE;
                 else if (!gie || !eligible[irq_id]) state_nxt = S_IDLE;
      S_SAVE:    state_nxt = S_SERVICE;
      S_SERVICE: if (bus.reti) state_nxt = S_RESTORE;
      S_RESTORE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    irq_req    = (state == S_REQ);
    int_save   = (state == S_SAVE);
    int_load   = (state == S_RESTORE);
    in_service = (state == S_SERVICE);
    clr        = '0;
    if (state == S_SAVE) clr[irq_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_d   <= '0;
      pending <= '0;
      mask    <= '0;
      gie     <= 1'b0;
      irq_id  <= '0;
      irq_vec <= '0;
    end else begin
      irq_d   <= bus.irq;
      // A fresh edge on the bit being serviced survives its clear
      pending <= (pending & ~clr) | edges;
      if (bus.mask_wr) mask <= bus.mask_din;
      if (state == S_SAVE)         gie <= 1'b0;
      else if (state == S_RESTORE) gie <= 1'b1;
      else if (bus.gie_clr)        gie <= 1'b0;
      else if (bus.gie_set)        gie <= 1'b1;
      if (state == S_IDLE && state_nxt == S_REQ) begin
        irq_id  <= win_id;
        irq_vec <= win_vec;
      end
    end
  end

  assign bus.irq_req    = irq_req;
  assign bus.irq_id     = irq_id;
  assign bus.irq_vec    = irq_vec;
  assign bus.int_save   = int_save;
  assign bus.int_load   = int_load;
  assign bus.int_wreg   = int_save | int_load;
  assign bus.in_service = in_service;
  assign bus.pending    = pending;
  assign bus.mask       = mask;
  assign bus.gie        = gie;
endmodule

// File: tb/tb_int_ctrl.sv
// Directed and randomized checks of int_ctrl against a cycle-level behavioural model.
module tb_int_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int_ctrl_if #(.NIRQ(4), .VEC_W(8)) bus ();

  int_ctrl #(.NIRQ(4), .VEC_W(8), .VEC_BASE(32'h10), .VEC_STRIDE(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef enum int {P_IDLE, P_ASKING, P_SAVING, P_HANDLER, P_RETURNING} phase_t;

  int checks = 0;
  int failures = 0;

  phase_t      m_phase;
  int unsigned m_pend, m_mask, m_prev, m_id, m_vec;
  bit          m_gie;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned lowest(input int unsigned v);
    for (int unsigned i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    m_pend = 0; m_mask = 0; m_prev = 0; m_id = 0; m_vec = 0; m_gie = 0;
  endtask

  // One rising clock edge of the behavioural model using the current inputs
  task automatic model_step();
    int unsigned irq_now, e, elig;
    phase_t nph;
    irq_now = 32'(bus.irq);
    e = irq_now & ~m_prev & 32'hF;
    m_prev = irq_now;
    elig = m_pend & m_mask;
    nph = m_phase;
    case (m_phase)
      P_IDLE: if (m_gie && elig != 0) begin
        nph = P_ASKING;
        m_id = lowest(elig);
        m_vec = (16 + 4 * m_id) & 32'hFF;
      end
      P_ASKING: if (bus.int_ack) nph = P_SAVING;
                else if (!m_gie || elig[m_id] == 1'b0) nph = P_IDLE;
      P_SAVING: nph = P_HANDLER;
      P_HANDLER: if (bus.reti) nph = P_RETURNING;
      P_RETURNING: nph = P_IDLE;
      default: nph = P_IDLE;
    endcase
    if (m_phase == P_SAVING) m_pend = m_pend & ~(32'd1 << m_id);
    m_pend = m_pend | e;
    if (bus.mask_wr) m_mask = 32'(bus.mask_din);
    if (m_phase == P_SAVING) m_gie = 0;
    else if (m_phase == P_RETURNING) m_gie = 1;
    else if (bus.gie_clr) m_gie = 0;
    else if (bus.gie_set) m_gie = 1;
    m_phase = nph;
  endtask

  task automatic compare_all();
    check("irq_req",    32'(bus.irq_req),    32'(m_phase == P_ASKING));
    check("irq_id",     32'(bus.irq_id),     m_id);
    check("irq_vec",    32'(bus.irq_vec),    m_vec);
    check("int_save",   32'(bus.int_save),   32'(m_phase == P_SAVING));
    check("int_load",   32'(bus.int_load),   32'(m_phase == P_RETURNING));
    check("int_wreg",   32'(bus.int_wreg),   32'(m_phase == P_SAVING || m_phase == P_RETURNING));
    check("in_service", 32'(bus.in_service), 32'(m_phase == P_HANDLER));
    check("pending",    32'(bus.pending),    m_pend);
    check("mask",       32'(bus.mask),       m_mask);
    check("gie",        32'(bus.gie),        32'(m_gie));
  endtask

  task automatic tick();
    if (!rst_n) model_reset();
    else        model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic pulses_off();
    bus.mask_wr = 1'b0; bus.gie_set = 1'b0; bus.gie_clr = 1'b0;
    bus.int_ack = 1'b0; bus.reti = 1'b0;
  endtask

  initial begin
    bus.irq = '0; bus.mask_din = '0;
    pulses_off();
    model_reset();
    #1;
    compare_all();
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Enable everything; single request on line 2
    bus.gie_set = 1'b1; bus.mask_wr = 1'b1; bus.mask_din = 4'hF;
    tick(); pulses_off();
    bus.irq = 4'b0100;
    tick();
    check("t2_no_req_yet", 32'(bus.irq_req), 0);
    tick();
    check("t2_req", 32'(bus.irq_req), 1);
    check("t2_id", 32'(bus.irq_id), 2);
    check("t2_vec", 32'(bus.irq_vec), 32'h18);

    // Entry and return handshake
    bus.int_ack = 1'b1; tick(); pulses_off();
    check("t4_save", 32'({bus.int_save, bus.int_wreg}), 32'b11);
    tick();
    check("t4_service", 32'({bus.in_service, bus.gie, bus.pending[2]}), 32'b100);
    bus.reti = 1'b1; tick(); pulses_off();
    check("t4_load", 32'({bus.int_load, bus.int_wreg, bus.int_save}), 32'b110);
    tick();
    check("t4_gie_back", 32'({bus.gie, bus.int_load}), 32'b10);
    bus.irq = '0; tick();

    // Simultaneous lines 3 and 1
    bus.irq = 4'b1010; tick(); tick();
    check("t3_id", 32'(bus.irq_id), 1);
    check("t3_vec", 32'(bus.irq_vec), 32'h14);
    bus.int_ack = 1'b1; tick(); pulses_off(); tick();
    bus.reti = 1'b1; tick(); pulses_off(); tick();
    check("t3_pending_left", 32'(bus.pending), 32'b1000);
    tick();
    check("t3_second_id", 32'({bus.irq_req, bus.irq_id}), 32'b111);
    bus.int_ack = 1'b1; tick(); pulses_off(); tick();
    bus.reti = 1'b1; tick(); pulses_off(); tick();
    bus.irq = '0; tick();

    // Masked line pends without requesting until unmasked
    bus.mask_wr = 1'b1; bus.mask_din = 4'b0000; tick(); pulses_off();
    bus.irq = 4'b0001; tick(); tick();
    check("t5_pending", 32'({bus.pending, bus.irq_req}), 32'b00010);
    bus.mask_wr = 1'b1; bus.mask_din = 4'b0001; tick(); pulses_off();
    check("t5_still_idle", 32'(bus.irq_req), 0);
    tick();
    check("t5_req", 32'(bus.irq_req), 1);

    // Withdrawal by gie_clr, then an edge during SAVE keeps the bit pending
    bus.irq = '0;
    bus.gie_clr = 1'b1; tick(); pulses_off();
    tick();
    check("t6_withdrawn", 32'({bus.irq_req, bus.pending}), 32'b00001);
    bus.gie_set = 1'b1; tick(); pulses_off(); tick();
    check("t6_req_again", 32'(bus.irq_req), 1);
    bus.int_ack = 1'b1; tick(); pulses_off();
    bus.irq = 4'b0001; tick();
    check("t6_edge_wins", 32'({bus.in_service, bus.pending[0]}), 32'b11);
    bus.reti = 1'b1; tick(); pulses_off(); tick(); tick();
    check("t6_rerequest", 32'(bus.irq_req), 1);

    // Reset while a handler runs
    bus.int_ack = 1'b1; tick(); pulses_off(); tick();
    check("t1_in_service", 32'(bus.in_service), 1);
    rst_n = 1'b0; #1;
    model_reset();
    compare_all();
    bus.reti = 1'b1; tick(); tick();
    rst_n = 1'b1; pulses_off();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t1_no_load", 32'(bus.int_load), 0);
    end

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) bus.irq[b] = ~bus.irq[b];
      bus.mask_wr  = ($urandom_range(15) == 0);
      bus.mask_din = 4'($urandom);
      bus.gie_set  = ($urandom_range(7) == 0);
      bus.gie_clr  = ($urandom_range(31) == 0);
      bus.int_ack  = ($urandom_range(2) == 0);
      bus.reti     = ($urandom_range(3) == 0);
      tick();
      check("excl_save_load", 32'(bus.int_save & bus.int_load), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
